// File: rtl/dmem_lsu.sv
// Load/store unit bridging the memory stage to port A of the 64 KiB data RAM.
// One outstanding access; loads absorb the RAM's one-cycle registered read.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal;
  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] extended;

  // Request checks: alignment, window range and funct3 legality.
  always_comb begin
    misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                   ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    out_of_range = (i_req_addr[31:16] != DMEM_BASE[31:16]);
    if (i_req_we)
      illegal = i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11);
    else
      illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
    req_err = misaligned || out_of_range || illegal;
  end

  // Handshake and RAM port A drive; address and write path gated by reset.
  always_comb begin
    o_req_ready = (state_q == IDLE) && i_reset;
    accept      = i_req_valid && o_req_ready;
    o_mem_wren  = '0;
    o_mem_wdata = '0;
    if (accept && i_req_we && !req_err) begin
      case (i_req_funct3[1:0])
        2'b00: begin
          o_mem_wdata = {4{i_req_wdata[7:0]}};
          o_mem_wren  = 4'b0001 << i_req_addr[1:0];
        end
        2'b01: begin
          o_mem_wdata = {2{i_req_wdata[15:0]}};
          o_mem_wren  = 4'b0011 << {i_req_addr[1], 1'b0};
        end
        default: begin
          o_mem_wdata = i_req_wdata;
          o_mem_wren  = 4'b1111;
        end
      endcase
    end
    if (state_q == IDLE)
      o_mem_addr = i_reset ? i_req_addr[15:0] : '0;
    else
      o_mem_addr = addr_q;
  end

  // Load data alignment and sign/zero extension.
  always_comb begin
    shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extended = {24'h000000, shifted[7:0]};
      3'b101:  extended = {16'h0000, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  // Next-state and response register update.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = i_req_addr[15:0];
          funct3_d = i_req_funct3;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err || i_req_we)
            state_d = RESP;
          else
            state_d = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        rdata_d = extended;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (i_rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural registered-read RAM on port A.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren;
  logic [31:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ram [0:16383];

  dmem_lsu #(.DMEM_BASE(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wren   (mem_wren),
    .i_mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Port A RAM: byte-enabled write, registered read-before-write.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wren[i]) ram[mem_addr[15:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= ram[mem_addr[15:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_wren, input logic [31:0] exp_wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    rsp_ready  = 1'b0;
    #3;
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".wren"}, {28'd0, mem_wren}, {28'd0, exp_wren});
    chk({tag, ".maddr"}, {16'd0, mem_addr}, {16'd0, addr[15:0]});
    if (we && !exp_err) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_5555;
    req_wdata  = 32'h0BAD_0BAD;
    chk({tag, ".wren_post"}, {28'd0, mem_wren}, 32'd0);
    chk({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
    if (!we && !exp_err) begin
      chk({tag, ".wait_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, ".wait_maddr"}, {16'd0, mem_addr}, {16'd0, addr[15:0]});
      @(posedge clk); #1;
    end
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, ".wren"}, {28'd0, mem_wren}, 32'd0);
    chk({tag, ".maddr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, ".wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_1234;
    req_wdata  = 32'hCAFE_F00D;
    rsp_ready  = 1'b0;
    #2;
    chk_all_zero("reset");
    req_valid = 1'b0;
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.ready", {31'd0, req_ready}, 32'd1);
    chk("post_reset.valid", {31'd0, rsp_valid}, 32'd0);

    // Word, byte and half accesses on the word at 0x100.
    access("sw100",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    access("lw100",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0);
    access("sb103",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080, 1'b0, 32'h0, 4'b1000, 32'h8080_8080);
    access("lb103",  1'b0, 3'b000, 32'h0000_0103, 32'h0,         1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
    access("lbu103", 1'b0, 3'b100, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_0080, 4'b0000, 32'h0);
    access("sh102",  1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1'b0, 32'h0, 4'b1100, 32'h1234_1234);
    access("lh100",  1'b0, 3'b001, 32'h0000_0100, 32'h0,         1'b0, 32'hFFFF_BEEF, 4'b0000, 32'h0);
    access("lhu102", 1'b0, 3'b101, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_1234, 4'b0000, 32'h0);
    access("lh102",  1'b0, 3'b001, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_1234, 4'b0000, 32'h0);
    access("lb101",  1'b0, 3'b000, 32'h0000_0101, 32'h0,         1'b0, 32'hFFFF_FFBE, 4'b0000, 32'h0);
    access("lbu100", 1'b0, 3'b100, 32'h0000_0100, 32'h0,         1'b0, 32'h0000_00EF, 4'b0000, 32'h0);
    access("lw100b", 1'b0, 3'b010, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_BEEF, 4'b0000, 32'h0);
    access("sb201",  1'b1, 3'b000, 32'h0000_0201, 32'hFFFF_FF5A, 1'b0, 32'h0, 4'b0010, 32'h5A5A_5A5A);
    access("lbu201", 1'b0, 3'b100, 32'h0000_0201, 32'h0,         1'b0, 32'h0000_005A, 4'b0000, 32'h0);
    access("sh200",  1'b1, 3'b001, 32'h0000_0200, 32'hABCD_7FFF, 1'b0, 32'h0, 4'b0011, 32'h7FFF_7FFF);
    access("lh200",  1'b0, 3'b001, 32'h0000_0200, 32'h0,         1'b0, 32'h0000_7FFF, 4'b0000, 32'h0);
    access("lbu201b",1'b0, 3'b100, 32'h0000_0201, 32'h0,         1'b0, 32'h0000_007F, 4'b0000, 32'h0);

    // Error cases: misaligned, out of range, illegal funct3.
    access("e_lh101",  1'b0, 3'b001, 32'h0000_0101, 32'h0,         1'b1, 32'h0, 4'b0000, 32'h0);
    access("e_sw102",  1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 1'b1, 32'h0, 4'b0000, 32'h0);
    access("e_lw_oor", 1'b0, 3'b010, 32'h0001_0000, 32'h0,         1'b1, 32'h0, 4'b0000, 32'h0);
    access("e_s_f100", 1'b1, 3'b100, 32'h0000_0100, 32'h3333_4444, 1'b1, 32'h0, 4'b0000, 32'h0);
    access("e_l_f011", 1'b0, 3'b011, 32'h0000_0100, 32'h0,         1'b1, 32'h0, 4'b0000, 32'h0);
    access("lw_after_err", 1'b0, 3'b010, 32'h0000_0100, 32'h0,     1'b0, 32'h1234_BEEF, 4'b0000, 32'h0);

    // Response backpressure with a competing request presented.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; req_wdata = 32'h1122_3344;
    for (int c = 0; c < 5; c++) begin
      chk("bp.valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp.rdata", rsp_rdata, 32'h1234_BEEF);
      chk("bp.ready", {31'd0, req_ready}, 32'd0);
      chk("bp.wren", {28'd0, mem_wren}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #3 chk("bp.consume_wren", {28'd0, mem_wren}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp.ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp.pending_wren", {28'd0, mem_wren}, 32'hF);
    chk("bp.pending_wdata", mem_wdata, 32'h1122_3344);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp.st_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp.st_err", {31'd0, rsp_err}, 32'd0);
    chk("bp.st_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    access("lw300", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 32'h1122_3344, 4'b0000, 32'h0);

    // Reset asserted while a load waits on RAM data.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_5678; req_wdata = 32'h9999_9999;
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    req_valid = 1'b0; rsp_ready = 1'b0;
    #3 rst_n = 1'b1;
    #1;
    chk("rel.ready", {31'd0, req_ready}, 32'd1);
    chk("rel.valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rel.no_stale", {31'd0, rsp_valid}, 32'd0);
    access("lw300_post", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 32'h1122_3344, 4'b0000, 32'h0);
    access("lw5678", 1'b0, 3'b010, 32'h0000_5678, 32'h0, 1'b0, ram[16'h5678 >> 2] === 32'h9999_9999 ? 32'hFFFF_FFFF : 32'h0 ^ ram[16'h5678 >> 2], 4'b0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the core's memory stage and port A of the 64 KiB synchronous data RAM. Accepts one load or store request at a time over a valid/ready handshake. Checks alignment and address range, generates byte enables with lane-replicated store data, and absorbs the RAM's one-cycle registered read latency. Returns sign- or zero-extended load data over a valid/ready response channel with an error flag.

## Interface
- DMEM_BASE, 32'h0000_0000: base of the 64 KiB window; only bits [31:16] are compared.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous and active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer takes the response.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned, out-of-range or illegal funct3.
- o_mem_addr  out  16  RAM byte address (to port A address).
- o_mem_wdata  out  32  RAM write data (to port A data).
- o_mem_wren  out  4  RAM byte write enables (to port A wren).
- i_mem_rdata  in  32  RAM registered read data (from port A q).

## Operation
- States: IDLE, LOAD_WAIT, RESP. o_req_ready = (state==IDLE) and reset deasserted.
- An access is accepted when i_req_valid && o_req_ready.
- Error conditions on accept:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Out of range: addr[31:16] ≠ DMEM_BASE[31:16].
  - Illegal funct3: stores with funct3 not in {000,001,010}; loads with funct3 ∈ {011,110,111}.
  - Erroneous access: o_mem_wren stays 0, state → RESP, err=1, rdata=0.
- Store accept: same cycle, o_mem_wren and o_mem_wdata are driven combinationally.
  - SB: wdata={4{b}}, wren=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wren=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=wdata, wren=4'b1111.
  - State → RESP with err=0, rdata=0.
- Load accept: wren=0, state → LOAD_WAIT. Latch addr[1:0] and funct3.
- LOAD_WAIT, one cycle: i_mem_rdata is valid. Shift right by 8*addr[1:0], then extend (B/H sign, BU/HU zero, W pass). Register the result into o_rsp_rdata, state → RESP.
- RESP: o_rsp_valid=1; rdata/err held stable until i_rsp_ready. On i_rsp_ready, state → IDLE. No new request is accepted in RESP.
- o_mem_addr:
  - IDLE: i_req_addr[15:0] combinationally.
  - Otherwise: latched request address.
- o_mem_wren is nonzero only in IDLE on an accepted, error-free store.

## Timing
- Reset (async, while low): state=IDLE, o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0.
- Reset mid-operation: pending access is dropped; no response is issued. A store write already committed at an earlier edge persists.
- Store accepted at edge N (RAM writes at N): o_rsp_valid from after N.
- Load accepted at edge N: RAM samples address at N; extended data registered at N+1; o_rsp_valid from after N+1.
- Error accepted at edge N: o_rsp_valid from after N.
- Response consumed at edge M (valid&&ready): o_req_ready=1 after M. Throughput: store 1 per 2 cycles, load 1 per 3 with zero backpressure.
- Request inputs are sampled only at the accept edge; later changes have no effect.
- The block never drives the RAM's port B. Writes on port B to the same word are not forwarded.

## Test plan
- Reset low mid-LOAD_WAIT → all outputs 0 immediately; after release, o_req_ready=1 and no stale o_rsp_valid.
- SW addr 0x0000_0100 data 0xDEADBEEF, then LW 0x100 → wren=4'b1111 at accept; load response 0xDEADBEEF, err=0, two cycles after accept.
- SB 0x103 data 0x80, then LB 0x103 → rdata 0xFFFF_FF80; then LBU 0x103 → 0x0000_0080; SB wren=4'b1000, wdata 0x80808080.
- SH 0x102 data 0x1234, then LH 0x100 → rdata = sign-extended low half of the word, unchanged. LHU 0x102 → 0x0000_1234.
- LH 0x101, SW 0x102, LW 0x0001_0000, store funct3=100 → each: err=1, rdata=0, o_mem_wren never nonzero, response one cycle after accept.
- LW with i_rsp_ready held 0 for 5 cycles → o_rsp_valid and rdata stable throughout, o_req_ready=0; a request presented meanwhile is accepted only after the response is consumed.
